// File: rtl/instruction_fetch_unit_if.sv
// ============================================================================
// Module : instruction_fetch_unit_if
// Brief  : Instruction-memory port and decoder handshake bundle for the fetch unit.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface instruction_fetch_unit_if #(
  parameter int ADDR_W = 16,
  parameter int INST_W = 32
);
  logic              i_fetch_en;
  logic [ADDR_W-1:0] o_imem_addr;
  logic [INST_W-1:0] i_imem_data;
  logic              i_redirect_valid;
  logic [ADDR_W-1:0] i_redirect_pc;
  logic              o_inst_valid;
  logic              i_inst_ready;
  logic [INST_W-1:0] o_inst;
  logic [ADDR_W-1:0] o_inst_pc;

  modport master (
    input  i_fetch_en, i_imem_data, i_redirect_valid, i_redirect_pc, i_inst_ready,
    output o_imem_addr, o_inst_valid, o_inst, o_inst_pc
  );

  modport slave (
    output i_fetch_en, i_imem_data, i_redirect_valid, i_redirect_pc, i_inst_ready,
    input  o_imem_addr, o_inst_valid, o_inst, o_inst_pc
  );
endinterface

`default_nettype wire

// File: rtl/instruction_fetch_unit.sv
// ============================================================================
// Module : instruction_fetch_unit
// Brief  : PC + prefetch FIFO feeding the decoder over valid/ready, with redirect flush.
//          Optional macro FETCH_PERF_CNT_EN adds o_fetch_count (pops since reset).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module instruction_fetch_unit #(
  parameter int              ADDR_W   = 16,
  parameter int              INST_W   = 32,
  parameter int              DEPTH    = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  wire logic                  clk,
  input  wire logic                  rst_n,
  instruction_fetch_unit_if.master   bus
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]                o_fetch_count
`endif
);

  localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_CNT_W = $clog2(DEPTH + 1);
  localparam logic [c_CNT_W-1:0] c_DEPTH_CNT = c_CNT_W'(DEPTH);

  logic [ADDR_W-1:0]  r_pc;
  logic [c_CNT_W-1:0] r_count;
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [INST_W-1:0]  r_mem_inst [DEPTH];
  logic [ADDR_W-1:0]  r_mem_pc   [DEPTH];

  logic w_valid;
  logic w_pop;
  logic w_push;

  // A redirect hides the head in the same cycle so the decoder never takes a stale word.
  assign w_valid = (r_count != '0) && !bus.i_redirect_valid;
  assign w_pop   = w_valid && bus.i_inst_ready;
  assign w_push  = bus.i_fetch_en && !bus.i_redirect_valid &&
                   ((r_count < c_DEPTH_CNT) || w_pop);

  assign bus.o_imem_addr  = r_pc;
  assign bus.o_inst_valid = w_valid;
  assign bus.o_inst       = r_mem_inst[r_rd_ptr];
  assign bus.o_inst_pc    = r_mem_pc[r_rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc     <= RESET_PC;
      r_count  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_inst[i] <= '0;
        r_mem_pc[i]   <= '0;
      end
    end else if (bus.i_redirect_valid) begin
      r_pc     <= bus.i_redirect_pc;
      r_count  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) begin
        r_mem_inst[r_wr_ptr] <= bus.i_imem_data;
        r_mem_pc[r_wr_ptr]   <= r_pc;
        r_wr_ptr             <= r_wr_ptr + 1'b1;
        r_pc                 <= r_pc + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_fetch_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_count <= '0;
    end else if (w_pop) begin
      r_fetch_count <= r_fetch_count + 32'd1;
    end
  end

  assign o_fetch_count = r_fetch_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_instruction_fetch_unit.sv
// ============================================================================
// Module : tb_instruction_fetch_unit
// Brief  : Directed self-checking bench for instruction_fetch_unit.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_instruction_fetch_unit;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;

  instruction_fetch_unit_if #(.ADDR_W(16), .INST_W(32)) u_if ();
  instruction_fetch_unit_if #(.ADDR_W(16), .INST_W(32)) u_if_wrap ();

  // Instruction memory model: imem[i] = A000_0000 + i
  assign u_if.i_imem_data      = 32'hA000_0000 + {16'h0, u_if.o_imem_addr};
  assign u_if_wrap.i_imem_data = 32'hA000_0000 + {16'h0, u_if_wrap.o_imem_addr};

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] w_fetch_count;
  logic [31:0] w_fetch_count_wrap;
`endif

  instruction_fetch_unit #(
    .ADDR_W(16), .INST_W(32), .DEPTH(2), .RESET_PC(16'h0000)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if.master)
`ifdef FETCH_PERF_CNT_EN
    ,
    .o_fetch_count (w_fetch_count)
`endif
  );

  instruction_fetch_unit #(
    .ADDR_W(16), .INST_W(32), .DEPTH(2), .RESET_PC(16'hFFFE)
  ) u_dut_wrap (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if_wrap.master)
`ifdef FETCH_PERF_CNT_EN
    ,
    .o_fetch_count (w_fetch_count_wrap)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [15:0] v_pc;
    n_checks = 0;
    n_pass   = 0;
    rst_n                      = 1'b0;
    u_if.i_fetch_en            = 1'b0;
    u_if.i_inst_ready          = 1'b0;
    u_if.i_redirect_valid      = 1'b0;
    u_if.i_redirect_pc         = 16'h0;
    u_if_wrap.i_fetch_en       = 1'b1;
    u_if_wrap.i_inst_ready     = 1'b1;
    u_if_wrap.i_redirect_valid = 1'b0;
    u_if_wrap.i_redirect_pc    = 16'h0;
    @(negedge clk);
    step();

    // Reset state
    check_eq("rst_valid",     {31'h0, u_if.o_inst_valid}, 32'h0);
    check_eq("rst_inst",      u_if.o_inst, 32'h0);
    check_eq("rst_inst_pc",   {16'h0, u_if.o_inst_pc}, 32'h0);
    check_eq("rst_addr",      {16'h0, u_if.o_imem_addr}, 32'h0);
    check_eq("rst_addr_wrap", {16'h0, u_if_wrap.o_imem_addr}, 32'h0000_FFFE);

    // Streaming fetch, plus the wrapping instance starting at FFFE
    rst_n = 1'b1;
    u_if.i_fetch_en   = 1'b1;
    u_if.i_inst_ready = 1'b1;
    check_eq("s1_empty_valid", {31'h0, u_if.o_inst_valid}, 32'h0);
    step();
    for (int i = 0; i < 4; i++) begin
      v_pc = 16'hFFFE + 16'(i);
      check_eq("s1_valid",   {31'h0, u_if.o_inst_valid}, 32'h1);
      check_eq("s1_inst_pc", {16'h0, u_if.o_inst_pc}, i);
      check_eq("s1_inst",    u_if.o_inst, 32'hA000_0000 + i);
      check_eq("wrap_inst_pc", {16'h0, u_if_wrap.o_inst_pc}, {16'h0, v_pc});
      check_eq("wrap_inst",    u_if_wrap.o_inst, 32'hA000_0000 + {16'h0, v_pc});
      step();
    end

    // Back-pressure: FIFO fills to 2 and pc stalls at 2
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    u_if.i_inst_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check_eq("s2_hold_pc",   {16'h0, u_if.o_inst_pc}, 32'h0);
      check_eq("s2_hold_inst", u_if.o_inst, 32'hA000_0000);
    end
    check_eq("s2_addr_stall", {16'h0, u_if.o_imem_addr}, 32'h2);
    u_if.i_inst_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check_eq("s2_drain_valid", {31'h0, u_if.o_inst_valid}, 32'h1);
      check_eq("s2_drain_pc",    {16'h0, u_if.o_inst_pc}, i);
      step();
    end

    // Redirect while full
    check_eq("s3_pre_addr", {16'h0, u_if.o_imem_addr}, 32'h5);
    u_if.i_redirect_valid = 1'b1;
    u_if.i_redirect_pc    = 16'h0007;
    #1;
    check_eq("s3_valid_forced0", {31'h0, u_if.o_inst_valid}, 32'h0);
    step();
    u_if.i_redirect_valid = 1'b0;
    check_eq("s3_flushed_valid", {31'h0, u_if.o_inst_valid}, 32'h0);
    check_eq("s3_addr",          {16'h0, u_if.o_imem_addr}, 32'h7);
    step();
    check_eq("s3_first_pc",   {16'h0, u_if.o_inst_pc}, 32'h7);
    check_eq("s3_first_inst", u_if.o_inst, 32'hA000_0007);
    step();
    check_eq("s3_second_pc",  {16'h0, u_if.o_inst_pc}, 32'h8);

    // Async reset with two entries buffered
    u_if.i_inst_ready = 1'b0;
    step();
    check_eq("s5_pre_valid", {31'h0, u_if.o_inst_valid}, 32'h1);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("s5_async_valid", {31'h0, u_if.o_inst_valid}, 32'h0);
    check_eq("s5_async_addr",  {16'h0, u_if.o_imem_addr}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    u_if.i_inst_ready = 1'b1;
    step();
    check_eq("s5_first_pc", {16'h0, u_if.o_inst_pc}, 32'h0);
    check_eq("s5_first_valid", {31'h0, u_if.o_inst_valid}, 32'h1);

    // fetch_en=0: pc frozen while the FIFO drains
    step();
    u_if.i_fetch_en = 1'b0;
    step();
    check_eq("fe0_drained", {31'h0, u_if.o_inst_valid}, 32'h0);
    step();
    check_eq("fe0_addr_hold", {16'h0, u_if.o_imem_addr}, 32'h2);
    u_if.i_fetch_en = 1'b1;
    step();
    check_eq("fe1_resume_pc", {16'h0, u_if.o_inst_pc}, 32'h2);

`ifdef FETCH_PERF_CNT_EN
    rst_n = 1'b0;
    step();
    check_eq("perf_rst", w_fetch_count, 32'h0);
    rst_n = 1'b1;
    step();
    for (int i = 0; i < 13; i++) begin
      u_if.i_inst_ready = (i % 4 == 3) ? 1'b0 : 1'b1;
      step();
    end
    check_eq("perf_count10", w_fetch_count, 32'd10);
    rst_n = 1'b0;
    #1;
    check_eq("perf_clear", w_fetch_count, 32'h0);
    rst_n = 1'b1;
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
